store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have ports: clk in 1 (system clock); rst_n in 1 (reset, asynchronous, active-low).
REQ-002 SHALL have ports: alloc_req in 1, rename-stage store allocation; alloc_ok out 1, grant; alloc_num out 3, granted entry number (sbnum).
REQ-003 SHALL have ports: agu_wen in 1, agu_num in 3, agu_addr in 32, agu_data in 32, agu_be in 4; these fill an allocated entry.
REQ-004 SHALL have ports: write1 in 1, sbnum1 in 3, write2 in 1, sbnum2 in 3; these are commit marks from the WB/COM stage.
REQ-005 SHALL have port flush in 1, which discards uncommitted entries on mispredict.
REQ-006 SHALL have ports: mem_req out 1, mem_addr out 32, mem_data out 32, mem_be out 4, mem_ack in 1; this is the data-memory drain port.
REQ-007 SHALL have ports: sb_full out 1, sb_empty out 1.
REQ-008 SHALL have ports: ld_addr in 32, fwd_hit out 1, fwd_stall out 1, fwd_data out 32; this is load forwarding.

Function
REQ-009 SHALL hold 8 entries in a circular queue with 4-bit head, cptr (commit) and tail pointers; the MSB is the wrap bit, and full = same index with differing wrap bit.
REQ-010 Entry states SHALL be FREE, ALLOC, READY and COMMITTED.
REQ-011 alloc_ok SHALL be combinational: alloc_req & ~sb_full & ~flush, using the count at the start of the cycle (no same-cycle drain bypass).
REQ-012 alloc_num SHALL equal tail[2:0]. A grant SHALL set that entry to ALLOC and increment tail at the clock edge.
REQ-013 agu_wen SHALL write addr/data/be into entry agu_num and move it ALLOC->READY in one cycle.
REQ-014 agu_wen to a non-ALLOC entry SHALL be ignored and flagged by an assertion.
REQ-015 write1 SHALL move entry sbnum1 READY->COMMITTED; write2 SHALL do the same for sbnum2.
REQ-016 Both commit marks SHALL be accepted in one cycle, and cptr SHALL advance by the number of marks (0/1/2).
REQ-017 Commits SHALL be in order: sbnum1 == cptr[2:0], and sbnum2 == cptr+1 (or cptr when write1=0). A violation or a non-READY target SHALL be flagged by an assertion.
REQ-018 mem_req SHALL be high whenever the head entry is COMMITTED.
REQ-019 mem_addr/mem_data/mem_be SHALL come from the head entry and stay stable until mem_ack.
REQ-020 On mem_req & mem_ack the head entry SHALL become FREE and head SHALL increment. At most one drain per cycle; mem_ack without mem_req SHALL be ignored.
REQ-021 flush SHALL free every ALLOC/READY entry and set tail <= cptr (post-commit value).
REQ-022 Commit marks in the flush cycle SHALL be applied before the flush. A drain in the flush cycle SHALL proceed normally.
REQ-023 agu_wen in the flush cycle SHALL be dropped.
REQ-024 sb_empty SHALL be (head == tail) and sb_full SHALL be the full condition; both are derived from registered pointers.
REQ-025 Simultaneous alloc and drain when full: alloc_ok=0; the drain completes; the entry becomes allocatable next cycle.
REQ-026 Pointer wrap 7->0 SHALL toggle the wrap bit; no entry is ever skipped.

Reset
REQ-027 When rst_n=0, all entries SHALL be FREE and head=cptr=tail=0.
REQ-028 Reset values SHALL be: mem_req=0, alloc_ok=0, sb_full=0, sb_empty=1, fwd_hit=0, fwd_stall=0, data outputs 0.
REQ-029 Reset asserted mid-drain SHALL abandon the memory transaction with no retry after release.

Configuration
REQ-030 Macro SB_FWD_EN defined: forwarding SHALL search READY/COMMITTED entries for the youngest one whose addr[31:2] matches ld_addr[31:2].
REQ-031 With SB_FWD_EN, a match with be=4'hF SHALL give fwd_hit=1 and fwd_data equal to that entry's data, combinationally.
REQ-032 With SB_FWD_EN, a match with partial be SHALL give fwd_stall=1 and fwd_hit=0.
REQ-033 Macro SB_FWD_EN undefined: the ports SHALL remain; fwd_hit, fwd_stall and fwd_data SHALL be tied to 0; no search logic.

Structure
REQ-034 Shared package sb_pkg SHALL hold SB_DEPTH=8, SB_IDX_W=3, SB_PTR_W=4, the entry-state enum, and the entry struct (addr, data, be, state).
REQ-035 The forwarding search SHALL be sub-module store_buffer_fwd, instantiated only under SB_FWD_EN; it takes the entry array plus head/tail and returns hit/stall/data.

Verification
REQ-036 Reset -> alloc 3, AGU-fill 3, commit entries 0,1 together -> mem_req=1, addr of entry 0; ack -> head=1, cptr=2.
REQ-037 Allocate 8 -> sb_full=1; 9th alloc_req -> alloc_ok=0; drain 1 -> alloc_ok=1 next cycle, alloc_num=0 (wrap).
REQ-038 5 allocated, 2 committed, flush -> tail=cptr=2, entries 2-4 FREE; the draining head completes on ack.
REQ-039 Flush with write1 for sbnum=2 in the same cycle -> entry 2 kept COMMITTED, tail=3.
REQ-040 SB_FWD_EN: two stores to 0x100 (data 0xA, then 0xB, be=F), load 0x100 -> fwd_hit=1, fwd_data=0xB; youngest be=4'h3 -> fwd_stall=1.
REQ-041 mem_ack held low 10 cycles -> mem_addr/mem_data unchanged; mem_ack while head is READY -> no state change.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the store buffer: entry states, entry record, pointer widths.
package sb_pkg;

  localparam int SB_DEPTH = 8;
  localparam int SB_IDX_W = 3;
  localparam int SB_PTR_W = 4;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_ALLOC     = 2'd1,
    SB_READY     = 2'd2,
    SB_COMMITTED = 2'd3
  } sb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    sb_state_e   state;
  } sb_entry_t;

  // An entry holds a known address/data once the AGU has filled it.
  function automatic logic sb_is_filled(sb_state_e s);
    return (s == SB_READY) || (s == SB_COMMITTED);
  endfunction

endpackage

// File: rtl/store_buffer_fwd.sv
// Store-to-load forwarding search: youngest filled entry whose word address matches the load.
module store_buffer_fwd
  import sb_pkg::*;
(
  input  sb_entry_t [SB_DEPTH-1:0] i_entries,
  input  logic [SB_PTR_W-1:0]      i_head,
  input  logic [SB_PTR_W-1:0]      i_tail,
  input  logic [31:0]              i_ld_addr,
  output logic                     o_hit,
  output logic                     o_stall,
  output logic [31:0]              o_data
);

  logic [SB_PTR_W-1:0] w_count;
  logic [SB_IDX_W-1:0] w_idx;
  logic                w_found;
  logic [31:0]         w_sel_data;
  logic [3:0]          w_sel_be;
  logic                w_unused_bits;

  assign w_count = i_tail - i_head;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    w_idx      = '0;
    w_found    = 1'b0;
    w_sel_data = '0;
    w_sel_be   = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_idx = i_head[SB_IDX_W-1:0] + SB_IDX_W'(i);
      if ((SB_PTR_W'(i) < w_count) && sb_is_filled(i_entries[w_idx].state) &&
          (i_entries[w_idx].addr[31:2] == i_ld_addr[31:2])) begin
        w_found    = 1'b1;
        w_sel_data = i_entries[w_idx].data;
        w_sel_be   = i_entries[w_idx].be;
      end
    end
  end

  always_comb begin
    w_unused_bits = ^i_ld_addr[1:0];
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_unused_bits = w_unused_bits ^ (^i_entries[i].addr[1:0]);
    end
  end

  assign o_hit   = w_found && (w_sel_be == 4'hF);
  assign o_stall = w_found && (w_sel_be != 4'hF);
  assign o_data  = o_hit ? w_sel_data : 32'h0;

endmodule

// File: rtl/store_buffer.sv
// 8-entry in-order store buffer: allocate, AGU fill, in-order commit, drain to memory.
// Optional load forwarding is enabled by defining SB_FWD_EN.
module store_buffer
  import sb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_req,
  output logic                alloc_ok,
  output logic [SB_IDX_W-1:0] alloc_num,
  input  logic                agu_wen,
  input  logic [SB_IDX_W-1:0] agu_num,
  input  logic [31:0]         agu_addr,
  input  logic [31:0]         agu_data,
  input  logic [3:0]          agu_be,
  input  logic                write1,
  input  logic [SB_IDX_W-1:0] sbnum1,
  input  logic                write2,
  input  logic [SB_IDX_W-1:0] sbnum2,
  input  logic                flush,
  output logic                mem_req,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_data,
  output logic [3:0]          mem_be,
  input  logic                mem_ack,
  output logic                sb_full,
  output logic                sb_empty,
  input  logic [31:0]         ld_addr,
  output logic                fwd_hit,
  output logic                fwd_stall,
  output logic [31:0]         fwd_data
);

  sb_entry_t [SB_DEPTH-1:0] r_ent;
  sb_entry_t [SB_DEPTH-1:0] w_ent_nxt;
  logic [SB_PTR_W-1:0]      r_head, r_cptr, r_tail;
  logic [SB_PTR_W-1:0]      w_head_nxt, w_cptr_nxt, w_tail_nxt;
  logic [SB_IDX_W-1:0]      w_head_idx, w_cptr_idx, w_tail_idx, w_c2_tgt;
  logic                     w_c1_ok, w_c2_ok, w_agu_ok, w_drain;
  logic [SB_PTR_W-1:0]      w_n_commit;

  assign w_head_idx = r_head[SB_IDX_W-1:0];
  assign w_cptr_idx = r_cptr[SB_IDX_W-1:0];
  assign w_tail_idx = r_tail[SB_IDX_W-1:0];

  // Full/empty come from registered pointers only, so a same-cycle drain never frees a slot early.
  assign sb_empty  = (r_head == r_tail);
  assign sb_full   = (w_head_idx == w_tail_idx) && (r_head[SB_PTR_W-1] != r_tail[SB_PTR_W-1]);
  assign alloc_ok  = alloc_req && !sb_full && !flush;
  assign alloc_num = w_tail_idx;

  assign mem_req  = (r_ent[w_head_idx].state == SB_COMMITTED);
  assign mem_addr = r_ent[w_head_idx].addr;
  assign mem_data = r_ent[w_head_idx].data;
  assign mem_be   = r_ent[w_head_idx].be;
  assign w_drain  = mem_req && mem_ack;

  // Second mark targets cptr+1 when paired with a first mark, otherwise cptr itself.
  assign w_c2_tgt   = write1 ? (w_cptr_idx + 3'd1) : w_cptr_idx;
  assign w_c1_ok    = write1 && (sbnum1 == w_cptr_idx) && (r_ent[sbnum1].state == SB_READY);
  assign w_c2_ok    = write2 && (!write1 || w_c1_ok) && (sbnum2 == w_c2_tgt) &&
                      (r_ent[sbnum2].state == SB_READY);
  assign w_n_commit = SB_PTR_W'(w_c1_ok) + SB_PTR_W'(w_c2_ok);
  assign w_agu_ok   = agu_wen && !flush && (r_ent[agu_num].state == SB_ALLOC);

  // NOTE: always_comb builds next state with blocking assignments in a fixed order
  // (commit, fill, drain, flush, alloc); later steps see earlier results.
  always_comb begin
    w_ent_nxt  = r_ent;
    w_cptr_nxt = r_cptr + w_n_commit;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    if (w_c1_ok) w_ent_nxt[sbnum1].state = SB_COMMITTED;
    if (w_c2_ok) w_ent_nxt[sbnum2].state = SB_COMMITTED;
    if (w_agu_ok) begin
      w_ent_nxt[agu_num].addr  = agu_addr;
      w_ent_nxt[agu_num].data  = agu_data;
      w_ent_nxt[agu_num].be    = agu_be;
      w_ent_nxt[agu_num].state = SB_READY;
    end
    if (w_drain) begin
      w_ent_nxt[w_head_idx].state = SB_FREE;
      w_head_nxt = r_head + 4'd1;
    end
    if (flush) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if ((w_ent_nxt[i].state == SB_ALLOC) || (w_ent_nxt[i].state == SB_READY)) begin
          w_ent_nxt[i].state = SB_FREE;
        end
      end
      w_tail_nxt = w_cptr_nxt;
    end else if (alloc_ok) begin
      w_ent_nxt[w_tail_idx].state = SB_ALLOC;
      w_tail_nxt = r_tail + 4'd1;
    end
  end

  // NOTE: the entry array is reset as a whole so the drain-port data outputs read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent  <= '0;
      r_head <= '0;
      r_cptr <= '0;
      r_tail <= '0;
    end else begin
      r_ent  <= w_ent_nxt;
      r_head <= w_head_nxt;
      r_cptr <= w_cptr_nxt;
      r_tail <= w_tail_nxt;
    end
  end

`ifdef SB_FWD_EN
  store_buffer_fwd u_fwd (
    .i_entries (r_ent),
    .i_head    (r_head),
    .i_tail    (r_tail),
    .i_ld_addr (ld_addr),
    .o_hit     (fwd_hit),
    .o_stall   (fwd_stall),
    .o_data    (fwd_data)
  );
`else
  logic w_unused_ld;
  assign w_unused_ld = ^ld_addr;
  assign fwd_hit     = 1'b0;
  assign fwd_stall   = 1'b0;
  assign fwd_data    = 32'h0;
`endif

  a_agu_target_alloc: assert property (@(posedge clk) disable iff (!rst_n)
    (agu_wen && !flush) |-> (r_ent[agu_num].state == SB_ALLOC));

  a_commit1_in_order: assert property (@(posedge clk) disable iff (!rst_n)
    write1 |-> ((sbnum1 == w_cptr_idx) && (r_ent[sbnum1].state == SB_READY)));

  a_commit2_in_order: assert property (@(posedge clk) disable iff (!rst_n)
    write2 |-> ((sbnum2 == w_c2_tgt) && (r_ent[sbnum2].state == SB_READY)));

endmodule
